// File: rtl/rle_pkg.sv
// Shared widths, FSM state type and destination word packing for the RLE job controller.
package rle_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned SYM_W    = 8;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned MEM_W    = 32;
    localparam int unsigned FLUSH_TO = 15;
    localparam int unsigned PAD_W    = MEM_W - SYM_W - CNT_W;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StFlush,
        StWait,
        StDone
    } state_e;

    function automatic logic [MEM_W-1:0] pack_dst_word(input logic [CNT_W-1:0] count,
                                                       input logic [SYM_W-1:0] sym);
        return {{PAD_W{1'b0}}, count, sym};
    endfunction

endpackage

// File: rtl/rle_job_ctrl_if.sv
// Host, source RAM, RLE core and destination RAM signals of the job controller.
interface rle_job_ctrl_if
    import rle_pkg::*;
();

    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W:0]   src_len;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W:0]   dst_limit;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   out_len;
    logic              overflow;

    logic [ADDR_W-1:0] src_addr;
    logic              src_rd_en;
    logic [MEM_W-1:0]  src_q;

    logic [SYM_W-1:0]  core_data_in;
    logic              core_valid_in;
    logic              core_flush;
    logic [SYM_W-1:0]  core_data_out;
    logic [CNT_W-1:0]  core_count_out;
    logic              core_valid_out;

    logic [ADDR_W-1:0] dst_addr;
    logic              dst_we;
    logic [MEM_W-1:0]  dst_wdata;

    modport slave (
        input  start, src_base, src_len, dst_base, dst_limit,
        input  src_q, core_data_out, core_count_out, core_valid_out,
        output busy, done, out_len, overflow,
        output src_addr, src_rd_en, core_data_in, core_valid_in, core_flush,
        output dst_addr, dst_we, dst_wdata
    );

    modport master (
        output start, src_base, src_len, dst_base, dst_limit,
        output src_q, core_data_out, core_count_out, core_valid_out,
        input  busy, done, out_len, overflow,
        input  src_addr, src_rd_en, core_data_in, core_valid_in, core_flush,
        input  dst_addr, dst_we, dst_wdata
    );

endinterface

// File: rtl/rle_wr_pack.sv
// Registers each accepted core run into one destination write, enforcing the word limit.
module rle_wr_pack
    import rle_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [ADDR_W:0]   dst_limit_i,
    input  logic              cap_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [SYM_W-1:0]  sym_i,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              dst_we_o,
    output logic [MEM_W-1:0]  dst_wdata_o,
    output logic [ADDR_W:0]   wcnt_o,
    output logic              overflow_o
);

    localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   limit_q, limit_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MEM_W-1:0]  wdata_q, wdata_d;

    always_comb begin
        base_d  = base_q;
        limit_d = limit_q;
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (clear_i) begin
            base_d  = dst_base_i;
            limit_d = dst_limit_i;
            wcnt_d  = '0;
            ovf_d   = 1'b0;
        end else if (cap_i) begin
            // A full buffer drops the run but the job keeps going.
            if (wcnt_q == limit_q) begin
                ovf_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = base_q + wcnt_q[ADDR_W-1:0];
                wdata_d = pack_dst_word(count_i, sym_i);
                wcnt_d  = wcnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q  <= '0;
            limit_q <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            base_q  <= base_d;
            limit_q <= limit_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign dst_addr_o  = addr_q;
    assign dst_we_o    = we_q;
    assign dst_wdata_o = wdata_q;
    assign wcnt_o      = wcnt_q;
    assign overflow_o  = ovf_q;

endmodule

// File: rtl/rle_job_ctrl.sv
// Job sequencer: streams a source buffer through the RLE core, flushes it and stores the runs.
module rle_job_ctrl
    import rle_pkg::*;
#(
    parameter int unsigned FlushTo = FLUSH_TO
) (
    input logic           clk_i,
    input logic           rst_ni,
    rle_job_ctrl_if.slave bus
);

    localparam int unsigned       TcntW    = (FlushTo > 1) ? $clog2(FlushTo) : 1;
    localparam logic [TcntW-1:0]  TcntLast = TcntW'(FlushTo - 1);
    localparam logic [TcntW-1:0]  TcntOne  = TcntW'(1);
    localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] src_addr_q;
    logic [ADDR_W:0]   rem_q;
    logic              rd_en_q;
    logic              vin_q;
    logic              flush_q;
    logic              busy_q;
    logic              done_q;
    logic [TcntW-1:0]  tcnt_q;

    logic              accept;
    logic              cap;
    logic              unused_src_hi;

    assign accept = (state_q == StIdle) && bus.start;
    assign cap    = bus.core_valid_out && (state_q inside {StRead, StFlush, StWait});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            src_addr_q <= '0;
            rem_q      <= '0;
            rd_en_q    <= 1'b0;
            vin_q      <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            // Read data returns one cycle after the issue, so the strobe trails rd_en.
            vin_q   <= rd_en_q;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        busy_q     <= 1'b1;
                        src_addr_q <= bus.src_base;
                        rem_q      <= bus.src_len;
                        if (bus.src_len == '0) begin
                            state_q <= StDone;
                        end else begin
                            rd_en_q <= 1'b1;
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (rem_q == LenOne) begin
                        rd_en_q <= 1'b0;
                        state_q <= StFlush;
                    end else begin
                        src_addr_q <= src_addr_q + AddrOne;
                        rem_q      <= rem_q - LenOne;
                    end
                end
                StFlush: begin
                    flush_q <= 1'b1;
                    tcnt_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // A run emitted alongside the flush pulse predates it; only a later one is final.
                    if ((bus.core_valid_out && !flush_q) || (tcnt_q == TcntLast)) begin
                        state_q <= StDone;
                    end else begin
                        tcnt_q <= tcnt_q + TcntOne;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    rle_wr_pack u_wr_pack (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (accept),
        .dst_base_i  (bus.dst_base),
        .dst_limit_i (bus.dst_limit),
        .cap_i       (cap),
        .count_i     (bus.core_count_out),
        .sym_i       (bus.core_data_out),
        .dst_addr_o  (bus.dst_addr),
        .dst_we_o    (bus.dst_we),
        .dst_wdata_o (bus.dst_wdata),
        .wcnt_o      (bus.out_len),
        .overflow_o  (bus.overflow)
    );

    assign unused_src_hi     = ^bus.src_q[MEM_W-1:SYM_W];
    assign bus.src_addr      = src_addr_q;
    assign bus.src_rd_en     = rd_en_q;
    assign bus.core_valid_in = vin_q;
    assign bus.core_data_in  = vin_q ? bus.src_q[SYM_W-1:0] : '0;
    assign bus.core_flush    = flush_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule
